// File: rtl/ctrl_seq_pkg.sv
// Shared types and constants for the control sequencer.
// State encodings, control-word select codes and opcodes.
package ctrl_seq_pkg;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'b00,
    ST_DECODE = 2'b01,
    ST_EXEC   = 2'b10,
    ST_HALT   = 2'b11
  } state_t;

  localparam logic [1:0] CW_IF  = 2'b00;
  localparam logic [1:0] CW_ID  = 2'b01;
  localparam logic [1:0] CW_EX  = 2'b10;
  localparam logic [1:0] CW_NOP = 2'b11;

  localparam logic [5:0] OP_LOAD  = 6'h23;
  localparam logic [5:0] OP_STORE = 6'h2B;
  localparam logic [5:0] OP_MUL   = 6'h1C;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam int CW_WIDTH_DEF = 47;

  function automatic logic is_mem_op(
    input logic [5:0] op
  );
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

  function automatic logic [1:0] cw_of(
    input state_t s
  );
    logic [1:0] cw;
    cw = CW_IF;
    unique case (s)
      ST_FETCH:  cw = CW_IF;
      ST_DECODE: cw = CW_ID;
      ST_EXEC:   cw = CW_EX;
      ST_HALT:   cw = CW_NOP;
      default:   cw = CW_IF;
    endcase
    return cw;
  endfunction

endpackage

// File: rtl/control_sequencer_exec_counter.sv
// 4-bit loadable down-counter timing multiply EXECUTE.
// Ports: i_clk, i_rst_n (sync), i_load, i_en, i_load_val, o_zero.
module exec_counter (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_load,
  input  logic       i_en,
  input  logic [3:0] i_load_val,
  output logic       o_zero
);

  logic [3:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != 4'd0)) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  assign o_zero = (r_cnt == 4'd0);

endmodule

// File: rtl/control_sequencer.sv
// FETCH/DECODE/EXECUTE/HALT sequencer driving a control-word mux select.
// In: clock, reset(n), mem_ready, stall, mem_rdata. Out: cw_sel, ir,
// ir_load, pc_en, mem_req, halted, state.
module control_sequencer
  import ctrl_seq_pkg::*;
#(
  parameter int MUL_CYCLES = 4,
  parameter int CW_WIDTH   = CW_WIDTH_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_ready,
  input  logic        stall,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  cw_sel,
  output logic [31:0] ir,
  output logic        ir_load,
  output logic        pc_en,
  output logic        mem_req,
  output logic        halted,
  output logic [1:0]  state
);

  if (MUL_CYCLES < 1 || MUL_CYCLES > 15) begin : g_bad_mul
    $error("MUL_CYCLES must be 1..15");
  end
  if (CW_WIDTH < 1) begin : g_bad_cw
    $error("CW_WIDTH must be positive");
  end

  localparam logic [3:0] MUL_LD = 4'(MUL_CYCLES - 1);

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_ir;
  logic [5:0]  w_op;
  logic        w_is_mem;
  logic        w_is_mul;
  logic        w_cnt_ld;
  logic        w_cnt_en;
  logic        w_cnt_zero;

  assign w_op     = r_ir[31:26];
  assign w_is_mem = is_mem_op(w_op);
  assign w_is_mul = (w_op == OP_MUL);

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= ST_FETCH;
      r_ir    <= '0;
    end else begin
      r_state <= w_next;
      if (ir_load) r_ir <= mem_rdata;
    end
  end

  exec_counter u_cnt (
    .i_clk      (clock),
    .i_rst_n    (reset),
    .i_load     (w_cnt_ld),
    .i_en       (w_cnt_en),
    .i_load_val (MUL_LD),
    .o_zero     (w_cnt_zero)
  );

  // Everything is gated by reset so outputs are quiet
  // even before the first edge with reset low.
  always_comb begin
    w_next   = r_state;
    ir_load  = 1'b0;
    pc_en    = 1'b0;
    mem_req  = 1'b0;
    halted   = 1'b0;
    w_cnt_ld = 1'b0;
    w_cnt_en = 1'b0;
    if (reset) begin
      unique case (r_state)
        ST_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready && !stall) begin
            ir_load = 1'b1;
            pc_en   = 1'b1;
            w_next  = ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (!stall) begin
            w_cnt_ld = w_is_mul;
            w_next   = (w_op == OP_HALT) ? ST_HALT
                                         : ST_EXEC;
          end
        end
        ST_EXEC: begin
          mem_req = w_is_mem;
          if (!stall) begin
            unique case (1'b1)
              w_is_mem: begin
                if (mem_ready) w_next = ST_FETCH;
              end
              w_is_mul: begin
                if (w_cnt_zero) w_next = ST_FETCH;
                else            w_cnt_en = 1'b1;
              end
              default: w_next = ST_FETCH;
            endcase
          end
        end
        ST_HALT: halted = 1'b1;
        default: w_next = ST_FETCH;
      endcase
    end
  end

  assign state  = reset ? r_state : ST_FETCH;
  assign cw_sel = reset ? cw_of(r_state) : CW_IF;
  assign ir     = r_ir;

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized self-checking bench for control_sequencer.
// Cycle-level reference model plus directed scenarios.
module tb_control_sequencer;

  localparam int MUL = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        mem_ready = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [1:0]  cw_sel;
  logic [31:0] ir;
  logic        ir_load;
  logic        pc_en;
  logic        mem_req;
  logic        halted;
  logic [1:0]  state;

  control_sequencer #(.MUL_CYCLES(MUL)) dut (
    .clock     (clock),
    .reset     (reset),
    .mem_ready (mem_ready),
    .stall     (stall),
    .mem_rdata (mem_rdata),
    .cw_sel    (cw_sel),
    .ir        (ir),
    .ir_load   (ir_load),
    .pc_en     (pc_en),
    .mem_req   (mem_req),
    .halted    (halted),
    .state     (state)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_err = 0;

  // model: phase 0=fetch 1=decode 2=execute 3=halt
  int          m_ph = 0;
  logic [31:0] m_ir = '0;
  int          m_left = 0;
  bit          m_known = 0;

  int n_ex, n_pc, n_ld, n_h;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic bit is_mem(input logic [31:0] w);
    return w[31:26] == 6'h23 || w[31:26] == 6'h2B;
  endfunction

  task automatic clr();
    n_ex = 0; n_pc = 0; n_ld = 0; n_h = 0;
  endtask

  task automatic cyc(input logic rst, input logic rdy,
                     input logic stl, input logic [31:0] rd);
    logic [1:0] e_cw;
    logic       e_req, e_ld, e_hlt;
    int         n_ph, n_left;
    logic [31:0] n_ir;
    reset = rst; mem_ready = rdy; stall = stl; mem_rdata = rd;
    #1;
    e_cw = 2'b00; e_req = 0; e_ld = 0; e_hlt = 0;
    if (rst) begin
      e_cw  = 2'(m_ph);
      e_req = (m_ph == 0) || (m_ph == 2 && is_mem(m_ir));
      e_ld  = (m_ph == 0) && rdy && !stl;
      e_hlt = (m_ph == 3);
    end
    chk("cw_sel", 32'(cw_sel), 32'(e_cw));
    chk("state", 32'(state), 32'(e_cw));
    chk("mem_req", 32'(mem_req), 32'(e_req));
    chk("ir_load", 32'(ir_load), 32'(e_ld));
    chk("pc_en", 32'(pc_en), 32'(e_ld));
    chk("halted", 32'(halted), 32'(e_hlt));
    if (m_known) chk("ir", ir, m_ir);
    if (cw_sel == 2'b10) n_ex++;
    if (pc_en) n_pc++;
    if (ir_load) n_ld++;
    if (halted) n_h++;
    n_ph = m_ph; n_ir = m_ir; n_left = m_left;
    if (!rst) begin
      n_ph = 0; n_ir = '0; n_left = 0;
    end else if (m_ph == 0) begin
      if (rdy && !stl) begin n_ir = rd; n_ph = 1; end
    end else if (m_ph == 1) begin
      if (!stl) begin
        n_ph = (m_ir[31:26] == 6'h3F) ? 3 : 2;
        n_left = (m_ir[31:26] == 6'h1C) ? MUL : 1;
      end
    end else if (m_ph == 2) begin
      if (!stl) begin
        if (is_mem(m_ir)) begin
          if (rdy) n_ph = 0;
        end else begin
          n_left = m_left - 1;
          if (n_left == 0) n_ph = 0;
        end
      end
    end
    @(posedge clock);
    #1;
    m_ph = n_ph; m_ir = n_ir; m_left = n_left;
    if (!rst) m_known = 1;
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [5:0] op;
    int k;
    k = $urandom_range(0, 15);
    if (k < 3)       op = 6'h23;
    else if (k < 5)  op = 6'h2B;
    else if (k < 8)  op = 6'h1C;
    else if (k == 8) op = 6'h3F;
    else             op = 6'($urandom);
    return {op, 26'($urandom)};
  endfunction

  initial begin
    #1;
    // reset and a single ALU instruction
    cyc(0, 1, 0, 32'h0);
    cyc(0, 0, 0, 32'h0);
    clr();
    cyc(1, 1, 0, 32'h0000_0001);
    cyc(1, 0, 0, 32'h0);
    cyc(1, 0, 0, 32'h0);
    chk("alu_ex_len", n_ex, 1);
    chk("alu_pc_en", n_pc, 1);

    // LOAD with three wait cycles
    clr();
    cyc(1, 1, 0, 32'h8C00_0000);
    cyc(1, 1, 0, 32'h0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 32'h0);
    cyc(1, 1, 0, 32'h0);
    chk("load_ex_len", n_ex, 4);
    chk("load_pc_en", n_pc, 1);

    // MUL stalled two cycles mid-execute
    clr();
    cyc(1, 1, 0, 32'h7000_0000);
    cyc(1, 1, 0, 32'h0);
    cyc(1, 1, 0, 32'h0);
    cyc(1, 1, 1, 32'h0);
    cyc(1, 0, 1, 32'h0);
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 32'h0);
    cyc(1, 0, 0, 32'h0);
    chk("mul_ex_len", n_ex, 6);
    chk("mul_pc_en", n_pc, 1);

    // HALT is sticky until reset
    cyc(1, 1, 0, 32'hFC00_0000);
    cyc(1, 0, 0, 32'h0);
    clr();
    for (int i = 0; i < 20; i++)
      cyc(1, 1'(i & 1), 1'($urandom), $urandom);
    chk("halt_len", n_h, 20);
    chk("halt_pc_en", n_pc, 0);
    cyc(0, 0, 0, 32'h0);
    cyc(1, 0, 0, 32'h0);

    // stalled fetch with ready present
    clr();
    for (int i = 0; i < 3; i++) cyc(1, 1, 1, 32'h0000_0002);
    cyc(1, 1, 0, 32'h0000_0002);
    cyc(1, 1, 0, 32'h0);
    cyc(1, 1, 0, 32'h0);
    cyc(1, 0, 0, 32'h0);
    chk("stall_fetch_ld", n_ld, 1);

    // reset in the middle of a multiply
    cyc(1, 1, 0, 32'h7000_0000);
    cyc(1, 0, 0, 32'h0);
    cyc(1, 1, 0, 32'h0);
    cyc(0, 1, 0, 32'h0);
    cyc(1, 0, 0, 32'h0);
    cyc(1, 1, 0, 32'h0000_0003);
    cyc(1, 0, 0, 32'h0);
    cyc(1, 0, 0, 32'h0);
    cyc(1, 0, 0, 32'h0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 59) != 0),
          1'($urandom),
          ($urandom_range(0, 3) == 0),
          rnd_instr());
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Parameter: MUL_CYCLES, default 4, number of EXECUTE cycles for a multiply (range 1..15).
REQ-002 Parameter: CW_WIDTH, default 47, control-word width served by the downstream 4:1 control-word mux.
REQ-003 Port: clock  input  1  single system clock, rising edge.
REQ-004 Port: reset  input  1  synchronous, active-low; sampled on rising clock edge.
REQ-005 Port: mem_ready  input  1  memory has completed the current request (fetch data or load/store).
REQ-006 Port: stall  input  1  freezes sequencing when high.
REQ-007 Port: mem_rdata  input  32  instruction word returned by memory during FETCH.
REQ-008 Port: cw_sel  output  2  select for the control-word mux: 00 IF, 01 ID, 10 EX, 11 HALT/NOP.
REQ-009 Port: ir  output  32  registered instruction register.
REQ-010 Port: ir_load  output  1  pulse: ir captures mem_rdata this edge.
REQ-011 Port: pc_en  output  1  pulse: PC advances this edge.
REQ-012 Port: mem_req  output  1  memory request outstanding.
REQ-013 Port: halted  output  1  sequencer in HALT.
REQ-014 Port: state  output  2  current FSM state, for debug.

Function
REQ-015 States: FETCH(00), DECODE(01), EXECUTE(10), HALT(11); cw_sel SHALL equal state (Moore decode).
REQ-016 Opcode SHALL be ir[31:26]; LOAD=6'h23, STORE=6'h2B (memory ops), MUL=6'h1C, HALT=6'h3F; all others ALU (1 cycle).
REQ-017 FETCH: mem_req=1; on mem_ready=1 and stall=0, ir<=mem_rdata, ir_load=1, pc_en=1, next DECODE; else remain.
REQ-018 DECODE: one cycle; next HALT if opcode HALT, else EXECUTE; counter loaded with MUL_CYCLES-1 if MUL.
REQ-019 EXECUTE, ALU: exactly one cycle, then FETCH.
REQ-020 EXECUTE, memory op: mem_req=1; remain until mem_ready=1, then FETCH; no timeout.
REQ-021 EXECUTE, MUL: remain while counter!=0, decrementing each unstalled cycle; exit to FETCH when counter==0; total MUL_CYCLES cycles.
REQ-022 HALT: halted=1, mem_req=0; sticky until reset; stall and mem_ready ignored.
REQ-023 stall=1 in FETCH/DECODE/EXECUTE: state, ir, counter hold; ir_load=0, pc_en=0; mem_req holds its state-decoded value.
REQ-024 mem_ready=1 with stall=1: ignored (not latched); memory SHALL re-present mem_ready after stall drops.
REQ-025 mem_ready outside FETCH or memory-op EXECUTE SHALL have no effect.
REQ-026 ir_load, pc_en, mem_req, halted SHALL be combinational from registered state, opcode, counter, and inputs; no output registered beyond state, ir, counter.
REQ-027 At most one ir_load and one pc_en per instruction.

Reset
REQ-028 reset=0 at a rising edge SHALL force state=FETCH, ir=32'h0, counter=0, from any state including HALT and mid-EXECUTE.
REQ-029 While reset=0: cw_sel=00, mem_req=0, ir_load=0, pc_en=0, halted=0.
REQ-030 First FETCH request SHALL appear in the first cycle after reset returns high.

Structure
REQ-031 Shared package ctrl_seq_pkg SHALL hold state encodings, cw_sel codes, opcode constants, and CW_WIDTH default.
REQ-032 One sub-module exec_counter (4-bit loadable down-counter with load, enable, zero flag) SHALL implement the MUL cycle count.
REQ-033 Control-word mux stays external; this block drives only its select.

Verification
REQ-034 Reset then mem_ready=1 with mem_rdata=32'h0000_0001 -> ir_load/pc_en pulse in cycle 1; cw_sel sequence 00,01,10,00.
REQ-035 mem_rdata=32'h8C00_0000 (LOAD), mem_ready low 3 EXECUTE cycles then high -> EXECUTE lasts 4 cycles, mem_req=1 throughout, back to FETCH.
REQ-036 mem_rdata=32'h7000_0000 (MUL), MUL_CYCLES=4, stall=1 for 2 cycles mid-EXECUTE -> EXECUTE lasts 6 cycles; pc_en pulses once.
REQ-037 mem_rdata=32'hFC00_0000 (HALT) -> cw_sel=11, halted=1 held for 20 cycles with mem_ready toggling; reset=0 -> FETCH next cycle.
REQ-038 stall=1 with mem_ready=1 in FETCH for 3 cycles -> no ir_load; stall drops with mem_ready=1 -> single ir_load.
REQ-039 reset=0 asserted in EXECUTE of MUL (counter=2) -> next cycle state=00, ir=0, counter=0, all pulses low.
